load_store_unit: RTL and testbench

Load/store unit between the execute stage and the word-wide data memory (`memory`, WIDTH=32, DEPTH=16). It converts byte-addressed MIPS loads and stores (LB/LBU/LH/LHU/LW/SB/SH/SW) into word accesses. Sub-word loads are extracted and sign- or zero-extended. Sub-word stores use a read-modify-write sequence, because the memory supports only full-word writes. The unit stalls the pipeline with `req_ready` while an access is in flight and delivers load data to writeback.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_if.sv | 34 +++
 rtl/lsu_align.sv | 45 ++++
 rtl/load_store_unit.sv | 121 ++++++++++++
 tb/tb_load_store_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [3:0] {
        LB  = 4'b0000,
        LH  = 4'b0001,
        LW  = 4'b0010,
        LBU = 4'b0100,
        LHU = 4'b0101,
        SB  = 4'b1000,
        SH  = 4'b1001,
        SW  = 4'b1010
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR
    } state_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_t;

    function automatic logic is_load(op_t op);
        return op inside {LB, LH, LW, LBU, LHU};
    endfunction

    function automatic logic is_store(op_t op);
        return op inside {SB, SH, SW};
    endfunction

    // Access size lives in the two LSBs of every load/store encoding.
    function automatic size_t size(op_t op);
        return size_t'(op[1:0]);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response and data-memory bus of the load/store unit.
interface lsu_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    import lsu_pkg::*;

    logic             req_valid;
    logic             req_ready;
    op_t              req_op;
    logic [31:0]      req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_rdata;
    logic             misalign;
    logic             mem_read;
    logic             mem_write;
    logic [DEPTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wd;
    logic [WIDTH-1:0] mem_rd;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, misalign,
               mem_read, mem_write, mem_addr, mem_wd
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, misalign,
               mem_read, mem_write, mem_addr, mem_wd
    );

endinterface

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, and lane merge for
// sub-word read-modify-write stores. Purely combinational.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  size_t            size_i,
    input  logic             unsigned_i,
    input  logic [1:0]       offset_i,
    input  logic [WIDTH-1:0] rdata_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] load_data_o,
    output logic [WIDTH-1:0] store_word_o
);

    logic [7:0]       byte_lane;
    logic [15:0]      half_lane;
    logic [WIDTH-1:0] lane_mask;
    logic [WIDTH-1:0] lane_data;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        byte_lane   = rdata_i[{offset_i, 3'b000} +: 8];
        half_lane   = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        load_data_o = rdata_i;
        lane_mask   = '1;
        lane_data   = wdata_i;
        case (size_i)
            BYTE: begin
                load_data_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
                lane_mask   = 32'h0000_00FF << {offset_i, 3'b000};
                lane_data   = {4{wdata_i[7:0]}};
            end
            HALF: begin
                load_data_o = {{16{~unsigned_i & half_lane[15]}}, half_lane};
                lane_mask   = offset_i[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                lane_data   = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
        store_word_o = (rdata_i & ~lane_mask) | (lane_data & lane_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed MIPS loads/stores into word accesses
// on a full-word-write data memory, stalling the requester while busy.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    lsu_if.slave bus
);

    state_t           state_q;
    size_t            size_q;
    logic             uns_q;
    logic [1:0]       offset_q;
    logic [DEPTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic             resp_valid_q;
    logic [WIDTH-1:0] resp_rdata_q;
    logic             mis_pend_q;
    logic             misalign_q;

    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] merged_word;
    size_t            req_size;
    logic             req_ld;
    logic             req_st;
    logic             req_bad;
    state_t           accept_state;
    logic             unused_addr_hi;

    assign unused_addr_hi = ^bus.req_addr[31:DEPTH+2];

    always_comb begin
        req_size     = size(bus.req_op);
        req_ld       = is_load(bus.req_op);
        req_st       = is_store(bus.req_op);
        req_bad      = (req_ld || req_st) &&
                       ((req_size == HALF && bus.req_addr[0]) ||
                        (req_size == WORD && bus.req_addr[1:0] != 2'b00));
        accept_state = IDLE;
        if (!req_bad) begin
            if (req_ld)      accept_state = LOAD;
            else if (req_st) accept_state = (req_size == WORD) ? STORE : RMW_RD;
        end
    end

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .size_i       (size_q),
        .unsigned_i   (uns_q),
        .offset_i     (offset_q),
        .rdata_i      (bus.mem_rd),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_word_o (merged_word)
    );

    // A rejected request is flagged one cycle after it would have started,
    // lining misalign up with where a load's resp_valid would appear.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            // NOTE: address/data holding registers are reset too, so mem_addr and mem_wd read 0 after reset.
            state_q      <= IDLE;
            size_q       <= BYTE;
            uns_q        <= 1'b0;
            offset_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            mis_pend_q   <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            mis_pend_q   <= 1'b0;
            misalign_q   <= mis_pend_q;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        size_q     <= req_size;
                        uns_q      <= bus.req_op[2];
                        offset_q   <= bus.req_addr[1:0];
                        addr_q     <= bus.req_addr[DEPTH+1:2];
                        wdata_q    <= bus.req_wdata;
                        mis_pend_q <= req_bad;
                        state_q    <= accept_state;
                    end
                end
                LOAD: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= load_data;
                    state_q      <= IDLE;
                end
                STORE:   state_q <= IDLE;
                RMW_RD:  state_q <= RMW_WR;
                RMW_WR:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            STORE:   bus.mem_wd = wdata_q;
            RMW_WR:  bus.mem_wd = merged_word;
            default: bus.mem_wd = '0;
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.mem_read   = (state_q == LOAD)  || (state_q == RMW_RD);
    assign bus.mem_write  = (state_q == STORE) || (state_q == RMW_WR);
    assign bus.mem_addr   = addr_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.misalign   = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a word memory driven by the DUT,
// plus a byte-addressed reference model of what memory and loads should hold.
`timescale 1ns/1ps
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam logic [31:0] BYTE_MASK = (32'h1 << (DEPTH + 2)) - 32'h1;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    lsu_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    load_store_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Data memory: writes on posedge, reads on negedge, cleared by reset.
    logic [31:0] mem [int];

    function automatic logic [31:0] mem_word(int w);
        return mem.exists(w) ? mem[w] : 32'h0;
    endfunction

    always @(posedge clk) begin
        if (rst) mem.delete();
        else if (bus.mem_write) mem[int'(bus.mem_addr)] = bus.mem_wd;
    end

    always @(negedge clk) begin
        if (rst) bus.mem_rd <= '0;
        else if (bus.mem_read) bus.mem_rd <= mem_word(int'(bus.mem_addr));
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (bus.mem_read && bus.mem_write) begin
                errors++;
                $display("FAIL rd_wr_exclusive t=%0t: got mem_read=1 mem_write=1, want not both", $time);
            end
        end
    end

    // Reference model: byte-addressed, little-endian.
    logic [7:0] ref_mem [int];

    function automatic logic [7:0] ref_byte(logic [31:0] a);
        int k;
        k = int'(a & BYTE_MASK);
        return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
    endfunction

    function automatic logic [31:0] ref_word(logic [31:0] a);
        return {ref_byte(a + 3), ref_byte(a + 2), ref_byte(a + 1), ref_byte(a)};
    endfunction

    function automatic logic [31:0] ref_load(logic [3:0] code, logic [31:0] a);
        logic [7:0] b0, b1;
        b0 = ref_byte(a);
        b1 = ref_byte(a + 1);
        case (code)
            4'b0000: return {{24{b0[7]}}, b0};
            4'b0100: return {24'h0, b0};
            4'b0001: return {{16{b1[7]}}, b1, b0};
            4'b0101: return {16'h0, b1, b0};
            default: return ref_word(a);
        endcase
    endfunction

    task automatic ref_store(input logic [3:0] code, input logic [31:0] a, input logic [31:0] d);
        ref_mem[int'(a & BYTE_MASK)] = d[7:0];
        if (code != 4'b1000) ref_mem[int'((a + 1) & BYTE_MASK)] = d[15:8];
        if (code == 4'b1010) begin
            ref_mem[int'((a + 2) & BYTE_MASK)] = d[23:16];
            ref_mem[int'((a + 3) & BYTE_MASK)] = d[31:24];
        end
    endtask

    function automatic int nbytes(logic [3:0] code);
        case (code)
            4'b0000, 4'b0100, 4'b1000: return 1;
            4'b0001, 4'b0101, 4'b1001: return 2;
            4'b0010, 4'b1010:          return 4;
            default:                   return 0;
        endcase
    endfunction

    // Issue one request (caller is 1ns after a posedge with the unit idle),
    // observe three cycles and compare against the expected protocol.
    task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] d);
        logic [2:0]       g_rdy, g_rv, g_mis, g_rd, g_wr;
        logic [2:0]       e_rdy, e_rv, e_mis, e_rd, e_wr;
        logic [31:0]      g_data, e_data;
        logic [DEPTH-1:0] g_addr;
        int               n;
        bit               ld, st, bad;
        n   = nbytes(code);
        ld  = (code inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101});
        st  = (code inside {4'b1000, 4'b1001, 4'b1010});
        bad = (ld || st) && ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00));
        e_data = ref_load(code, a);

        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before op=%h addr=%h: got %b want 1", code, a, bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op_t'(code);
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_op    = op_t'(4'($urandom_range(0, 15)));
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;

        g_addr = bus.mem_addr;
        g_data = '0;
        for (int i = 0; i < 3; i++) begin
            g_rdy[i] = bus.req_ready;
            g_rv[i]  = bus.resp_valid;
            g_mis[i] = bus.misalign;
            g_rd[i]  = bus.mem_read;
            g_wr[i]  = bus.mem_write;
            if (i == 1) g_data = bus.resp_rdata;
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end

        e_rdy = 3'b111; e_rv = 3'b000; e_mis = 3'b000; e_rd = 3'b000; e_wr = 3'b000;
        if (bad) e_mis = 3'b010;
        else if (ld) begin
            e_rdy = 3'b110; e_rv = 3'b010; e_rd = 3'b001;
        end else if (st && n == 4) begin
            e_rdy = 3'b110; e_wr = 3'b001;
        end else if (st) begin
            e_rdy = 3'b100; e_rd = 3'b001; e_wr = 3'b010;
        end

        checks += 5;
        if (g_rdy !== e_rdy) begin
            errors++;
            $display("FAIL req_ready op=%h addr=%h: got %b want %b", code, a, g_rdy, e_rdy);
        end
        if (g_rv !== e_rv) begin
            errors++;
            $display("FAIL resp_valid op=%h addr=%h: got %b want %b", code, a, g_rv, e_rv);
        end
        if (g_mis !== e_mis) begin
            errors++;
            $display("FAIL misalign op=%h addr=%h: got %b want %b", code, a, g_mis, e_mis);
        end
        if (g_rd !== e_rd) begin
            errors++;
            $display("FAIL mem_read op=%h addr=%h: got %b want %b", code, a, g_rd, e_rd);
        end
        if (g_wr !== e_wr) begin
            errors++;
            $display("FAIL mem_write op=%h addr=%h: got %b want %b", code, a, g_wr, e_wr);
        end
        if ((ld || st) && !bad) begin
            checks++;
            if (g_addr !== a[DEPTH+1:2]) begin
                errors++;
                $display("FAIL mem_addr op=%h addr=%h: got %h want %h", code, a, g_addr, a[DEPTH+1:2]);
            end
        end
        if (ld && !bad) begin
            checks++;
            if (g_data !== e_data) begin
                errors++;
                $display("FAIL resp_rdata op=%h addr=%h: got %h want %h", code, a, g_data, e_data);
            end
        end
        if (st && !bad) begin
            ref_store(code, a, d);
            checks++;
            if (mem_word(int'(a[DEPTH+1:2])) !== ref_word(a & ~32'h3)) begin
                errors++;
                $display("FAIL mem_contents op=%h addr=%h: got %h want %h", code, a,
                         mem_word(int'(a[DEPTH+1:2])), ref_word(a & ~32'h3));
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = LB;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        ref_mem.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks += 8;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
        if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata: got %h want 0", bus.resp_rdata); end
        if (bus.misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", bus.misalign); end
        if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b want 0", bus.mem_read); end
        if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b want 0", bus.mem_write); end
        if (bus.mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        if (bus.mem_wd !== 32'h0) begin errors++; $display("FAIL reset_mem_wd: got %h want 0", bus.mem_wd); end
    endtask

    task automatic test_word;
        run_op(SW, 32'h10, 32'hDEAD_BEEF);
        checks++;
        if (mem_word(4) !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL sw_commit: got %h want deadbeef", mem_word(4));
        end
        run_op(LW, 32'h10, $urandom);
    endtask

    task automatic test_subword_load;
        run_op(SW, 32'h10, 32'h8899_AABB);
        run_op(LB, 32'h13, $urandom);
        run_op(LBU, 32'h13, $urandom);
        run_op(LH, 32'h12, $urandom);
        run_op(LHU, 32'h10, $urandom);
    endtask

    task automatic test_rmw;
        run_op(SW, 32'h10, 32'h1122_3344);
        run_op(SB, 32'h11, 32'hABCD_EFEE);
        checks++;
        if (mem_word(4) !== 32'h1122_EE44) begin
            errors++;
            $display("FAIL sb_merge: got %h want 1122ee44", mem_word(4));
        end
        run_op(SH, 32'h12, 32'h1234_5566);
        checks++;
        if (mem_word(4) !== 32'h5566_EE44) begin
            errors++;
            $display("FAIL sh_merge: got %h want 5566ee44", mem_word(4));
        end
    endtask

    task automatic test_misalign;
        logic [31:0] w0, w1;
        run_op(SW, 32'h04, 32'hCAFE_F00D);
        run_op(SW, 32'h00, 32'h0123_4567);
        w0 = mem_word(0);
        w1 = mem_word(1);
        run_op(LW, 32'h06, $urandom);
        run_op(LH, 32'h03, $urandom);
        run_op(SH, 32'h01, 32'hFFFF_9999);
        run_op(4'b0011, 32'h00, $urandom);
        checks += 2;
        if (mem_word(0) !== w0) begin errors++; $display("FAIL misalign_mem0: got %h want %h", mem_word(0), w0); end
        if (mem_word(1) !== w1) begin errors++; $display("FAIL misalign_mem1: got %h want %h", mem_word(1), w1); end
    endtask

    task automatic test_random;
        logic [3:0]  valid_ops [8];
        logic [3:0]  code;
        logic [31:0] a;
        valid_ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) code = 4'($urandom_range(0, 15));
            else code = valid_ops[$urandom_range(0, 7)];
            a = ($urandom & 32'hFFFC_0000) | 32'($urandom_range(0, 31));
            run_op(code, a, $urandom);
        end
        for (int w = 0; w < 8; w++) begin
            checks++;
            if (mem_word(w) !== ref_word(32'(w * 4))) begin
                errors++;
                $display("FAIL random_mem word=%0d: got %h want %h", w, mem_word(w), ref_word(32'(w * 4)));
            end
        end
    endtask

    task automatic test_back_to_back;
        run_op(SW, 32'h08, 32'h0BAD_F00D);
        run_op(SW, 32'h0C, 32'h600D_CAFE);
        bus.req_valid = 1'b1;
        bus.req_op    = LW;
        bus.req_addr  = 32'h08;
        bus.req_wdata = $urandom;
        @(posedge clk); #1;
        bus.req_op   = LH;
        bus.req_addr = 32'h0E;
        checks += 2;
        if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy1: got ready=%b want 0", bus.req_ready); end
        if (bus.mem_addr !== 16'd2) begin errors++; $display("FAIL b2b_addr1: got %h want 0002", bus.mem_addr); end
        @(posedge clk); #1;
        checks += 3;
        if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_resp1_valid: got %b want 1", bus.resp_valid); end
        if (bus.resp_rdata !== ref_load(LW, 32'h08)) begin
            errors++; $display("FAIL b2b_resp1_data: got %h want %h", bus.resp_rdata, ref_load(LW, 32'h08));
        end
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_resp: got %b want 1", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checks += 3;
        if (bus.req_ready !== 1'b0 || bus.mem_read !== 1'b1) begin
            errors++; $display("FAIL b2b_accept2: got ready=%b mem_read=%b want 0/1", bus.req_ready, bus.mem_read);
        end
        if (bus.mem_addr !== 16'd3) begin errors++; $display("FAIL b2b_addr2: got %h want 0003", bus.mem_addr); end
        if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_resp_pulse: got %b want 0", bus.resp_valid); end
        @(posedge clk); #1;
        checks += 2;
        if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_resp2_valid: got %b want 1", bus.resp_valid); end
        if (bus.resp_rdata !== ref_load(LH, 32'h0E)) begin
            errors++; $display("FAIL b2b_resp2_data: got %h want %h", bus.resp_rdata, ref_load(LH, 32'h0E));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        run_op(SW, 32'h00, 32'h1357_2468);
        bus.req_valid = 1'b1;
        bus.req_op    = SB;
        bus.req_addr  = 32'h01;
        bus.req_wdata = 32'h77;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checks++;
        if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL rst_mid_in_rmw_rd: got mem_read=%b want 1", bus.mem_read); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_mem.delete();
        checks += 7;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", bus.req_ready); end
        if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL rst_mid_mem_read: got %b want 0", bus.mem_read); end
        if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL rst_mid_mem_write: got %b want 0", bus.mem_write); end
        if (bus.mem_addr !== '0) begin errors++; $display("FAIL rst_mid_mem_addr: got %h want 0", bus.mem_addr); end
        if (bus.mem_wd !== 32'h0) begin errors++; $display("FAIL rst_mid_mem_wd: got %h want 0", bus.mem_wd); end
        if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_resp_valid: got %b want 0", bus.resp_valid); end
        if (bus.misalign !== 1'b0) begin errors++; $display("FAIL rst_mid_misalign: got %b want 0", bus.misalign); end
        @(posedge clk); #1;
        checks++;
        if (bus.mem_write !== 1'b0 || bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_no_late_op: got wr=%b rv=%b want 0/0", bus.mem_write, bus.resp_valid);
        end
        run_op(LW, 32'h00, $urandom);
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword_load();
        test_rmw();
        test_misalign();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
